queue_enq_arbiter: RTL and testbench
====================================

Name: queue_enq_arbiter

Overview:
Round-robin arbiter that shares one enqueue port of a circular FIFO (the issue/memory-request queues) among NUM_REQ producers.
- Selects at most one requester per cycle and drives the queue's enq/d_in.
- Honours queue full and pipeline flush.
- Supports locked multi-beat bursts, so that one producer's consecutive entries land contiguously in the queue.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, entry width; matches the queue's WIDTH
IDX_W, $clog2(NUM_REQ), requester index width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush; abort arbitration and any lock
req  in  NUM_REQ  per-requester enqueue request
req_lock  in  NUM_REQ  requester wants to hold the grant after this beat
req_data  in  NUM_REQ*WIDTH  packed entries; requester i at bits [i*WIDTH +: WIDTH]
gnt  out  NUM_REQ  one-hot grant; entry accepted this cycle
q_enq  out  1  to queue enq
q_d_in  out  WIDTH  to queue d_in
q_full  in  1  from queue full
locked  out  1  arbiter in LOCKED state
owner  out  IDX_W  current lock owner (valid when locked)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset state: state=IDLE, rr_ptr=0, owner=0, locked=0.
- Grant outputs are combinational from registered state plus inputs, so an entry is accepted in the same cycle (zero latency). With no req, gnt=0, q_enq=0 and q_d_in=0.
- Blocked cycles: if q_full=1 or flush=1, then gnt=0, q_enq=0, and state, rr_ptr and owner are unchanged, except that flush forces state to IDLE.
- IDLE:
  - Search req starting at rr_ptr, upward, modulo NUM_REQ; the first asserted index i wins.
  - Drive gnt[i]=1, q_enq=1, q_d_in=req_data[i].
  - Next cycle: rr_ptr <= (i==NUM_REQ-1) ? 0 : i+1.
  - If req_lock[i]=1 at grant: state <= LOCKED and owner <= i.
- LOCKED:
  - Only owner is eligible; all other requests are masked.
  - If req[owner]=1 and the cycle is not blocked: grant the owner.
  - If req_lock[owner]=0 on that grant, it is the final beat: state <= IDLE and rr_ptr <= owner+1 mod NUM_REQ.
  - While locked, rr_ptr is frozen.
  - If the owner drops req, the arbiter stays LOCKED with no grants until the owner resumes or a flush occurs.
- Flush:
  - Highest priority after rst.
  - state <= IDLE; rr_ptr is preserved.
  - No grant in the flush cycle.
- Requester contract: req_data[i] and req_lock[i] are held stable while req[i]=1 and gnt[i]=0.
- Wrap-around: the search wraps from NUM_REQ-1 to 0. With a single requester active, it is granted every non-blocked cycle.
- The arbiter never asserts q_enq when q_full=1, so the queue's simultaneous enq/deq path is never relied on for correctness.
- Reset mid-burst: behaves as flush and additionally clears rr_ptr.

Optional Feature:
QARB_GNT_CNT_EN
- Defined:
  - Adds output gnt_cnt (NUM_REQ*32): per-requester grant counters.
  - Each counter increments on gnt[i] and saturates at 32'hFFFF_FFFF.
  - Counters clear on rst only; they are not cleared by flush.
- Undefined: the port and counters are absent; there is no functional difference.

Decomposition:
- Package queue_arb_pkg holds:
  - the enum arb_state_e {ARB_IDLE, ARB_LOCKED};
  - the function rr_next(idx, n) for modulo increment.
- Sub-module rr_pick: combinational rotate-priority picker (req vector, start pointer -> one-hot grant + index), instantiated once.

Test Plan:
- Reset, all req=0 -> gnt=0, q_enq=0, locked=0. Then req=4'b1111 for 4 cycles -> gnt sequence 0001, 0010, 0100, 1000; q_d_in equals req_data of each granted requester.
- rr_ptr=2, req=4'b0011 -> gnt=0001 first; next cycle gnt=0010 (wrap past 3).
- req[1] with req_lock[1]=1 for 3 beats, then req_lock=0 on the 4th, all req=1111 -> 4 consecutive gnt=0010, locked=1 on beats 2-4; next grant gnt=0100.
- req=1111 and q_full=1 for 3 cycles -> gnt=0 and q_enq=0 throughout, rr_ptr unchanged. q_full=0 -> grant resumes at the same index.
- Locked on owner 3, flush=1 for one cycle -> that cycle gnt=0; next cycle locked=0 and IDLE arbitration resumes from the preserved rr_ptr.
- With QARB_GNT_CNT_EN: 10 grants to requester 0 -> gnt_cnt[0]=10, others 0. A flush leaves the counts intact; rst zeroes them.

Source files
------------

// File: rtl/queue_enq_arbiter_pkg.sv
// Shared types and helpers for the queue enqueue arbiter.
// Defines the arbiter state encoding and the modulo-increment used by the round-robin pointer.
package queue_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/queue_enq_arbiter_rr_pick.sv
// Combinational rotate-priority picker: finds the first asserted request at or above start,
// wrapping modulo N, and returns it as a one-hot grant plus its binary index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/queue_enq_arbiter.sv
// Round-robin arbiter sharing one circular-FIFO enqueue port among NUM_REQ producers, with locked bursts.
// Optional build macro QARB_GNT_CNT_EN adds saturating per-requester grant counters on gnt_cnt.
module queue_enq_arbiter
    import queue_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_lock,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     q_enq,
    output logic [WIDTH-1:0]         q_d_in,
    input  logic                     q_full,
    output logic                     locked,
`ifdef QARB_GNT_CNT_EN
    output logic [IDX_W-1:0]         owner,
    output logic [NUM_REQ*32-1:0]    gnt_cnt
`else
    output logic [IDX_W-1:0]         owner
`endif
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .start (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // A full queue or a flush suppresses every grant; only flush alters state.
    always_comb begin
        gnt      = '0;
        q_enq    = 1'b0;
        q_d_in   = '0;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (flush) begin
            state_d = ARB_IDLE;
        end else if (!q_full) begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt      = pick_gnt;
                        q_enq    = 1'b1;
                        q_d_in   = req_data[int'(pick_idx)*WIDTH +: WIDTH];
                        rr_ptr_d = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
                        if (req_lock[pick_idx]) begin
                            state_d = ARB_LOCKED;
                            owner_d = pick_idx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (req[owner_q]) begin
                        gnt[owner_q] = 1'b1;
                        q_enq        = 1'b1;
                        q_d_in       = req_data[int'(owner_q)*WIDTH +: WIDTH];
                        if (!req_lock[owner_q]) begin
                            state_d  = ARB_IDLE;
                            rr_ptr_d = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    assign locked = (state_q == ARB_LOCKED);
    assign owner  = owner_q;

`ifdef QARB_GNT_CNT_EN
    logic [31:0] cnt_q [NUM_REQ];

    // Counters survive flush so software can read lifetime grant totals.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (cnt_q[i] != 32'hFFFF_FFFF)) cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign gnt_cnt[g*32 +: 32] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed self-checking bench for queue_enq_arbiter (NUM_REQ=4, WIDTH=32).
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
module tb_queue_enq_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic                     q_enq;
    logic [WIDTH-1:0]         q_d_in;
    logic                     q_full;
    logic                     locked;
    logic [1:0]               owner;
`ifdef QARB_GNT_CNT_EN
    logic [NUM_REQ*32-1:0]    gnt_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    queue_enq_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .req      (req),
        .req_lock (req_lock),
        .req_data (req_data),
        .gnt      (gnt),
        .q_enq    (q_enq),
        .q_d_in   (q_d_in),
        .q_full   (q_full),
        .locked   (locked),
`ifdef QARB_GNT_CNT_EN
        .owner    (owner),
        .gnt_cnt  (gnt_cnt)
`else
        .owner    (owner)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input int i);
        return 32'hCAFE_0000 + 32'(i) * 32'h11;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req = '0; req_lock = '0; q_full = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || q_enq !== 1'b0 || q_d_in !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_idle gnt=%b q_enq=%b q_d_in=%h expected 0000/0/0", gnt, q_enq, q_d_in);
        end
        checks++;
        if (locked !== 1'b0 || owner !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_state locked=%b owner=%0d expected 0/0", locked, owner);
        end
        cyc();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt;
        req = 4'b1111; req_lock = '0;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = 4'b0001 << k;
            #1;
            checks++;
            if (gnt !== exp_gnt || q_enq !== 1'b1 || q_d_in !== data_of(k)) begin
                failures++;
                $display("[TB] FAIL rotation_%0d gnt=%b q_enq=%b d=%h expected %b/1/%h",
                         k, gnt, q_enq, q_d_in, exp_gnt, data_of(k));
            end
            cyc();
        end
    endtask

    task automatic test_wrap();
        // rr_ptr is 0; granting requester 1 moves it to 2
        req = 4'b0010; #1;
        checks++;
        if (gnt !== 4'b0010) begin
            failures++; $display("[TB] FAIL wrap_setup gnt=%b expected 0010", gnt);
        end
        cyc();
        req = 4'b0011; #1;
        checks++;
        if (gnt !== 4'b0001 || q_d_in !== data_of(0)) begin
            failures++; $display("[TB] FAIL wrap_first gnt=%b d=%h expected 0001/%h", gnt, q_d_in, data_of(0));
        end
        cyc(); #1;
        checks++;
        if (gnt !== 4'b0010 || q_d_in !== data_of(1)) begin
            failures++; $display("[TB] FAIL wrap_second gnt=%b d=%h expected 0010/%h", gnt, q_d_in, data_of(1));
        end
        cyc();
        // rr_ptr is now 2; a grant to requester 0 leaves it at 1
        req = 4'b0001; #1;
        checks++;
        if (gnt !== 4'b0001) begin
            failures++; $display("[TB] FAIL wrap_single gnt=%b expected 0001", gnt);
        end
        cyc();
    endtask

    task automatic test_lock();
        req = 4'b1111; req_lock = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) req_lock = 4'b0000;
            #1;
            checks++;
            if (gnt !== 4'b0010 || locked !== (b != 0) || q_d_in !== data_of(1)) begin
                failures++;
                $display("[TB] FAIL lock_beat%0d gnt=%b locked=%b expected 0010/%b", b, gnt, locked, (b != 0));
            end
            cyc();
            if (b == 1) begin
                // owner pauses: others stay masked, lock held
                req = 4'b1101; #1;
                checks++;
                if (gnt !== 4'b0000 || q_enq !== 1'b0 || locked !== 1'b1 || owner !== 2'd1) begin
                    failures++;
                    $display("[TB] FAIL lock_pause gnt=%b q_enq=%b locked=%b owner=%0d expected 0000/0/1/1",
                             gnt, q_enq, locked, owner);
                end
                cyc();
                req = 4'b1111;
            end
        end
        #1;
        checks++;
        if (gnt !== 4'b0100 || locked !== 1'b0) begin
            failures++; $display("[TB] FAIL lock_release gnt=%b locked=%b expected 0100/0", gnt, locked);
        end
        cyc();
    endtask

    task automatic test_full();
        // rr_ptr is 3
        req = 4'b1111; req_lock = '0; q_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000 || q_enq !== 1'b0) begin
                failures++; $display("[TB] FAIL full_block%0d gnt=%b q_enq=%b expected 0000/0", c, gnt, q_enq);
            end
            cyc();
        end
        q_full = 1'b0; #1;
        checks++;
        if (gnt !== 4'b1000 || q_enq !== 1'b1 || q_d_in !== data_of(3)) begin
            failures++; $display("[TB] FAIL full_resume gnt=%b d=%h expected 1000/%h", gnt, q_d_in, data_of(3));
        end
        cyc();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0100 || q_enq !== 1'b1) begin
                failures++; $display("[TB] FAIL single_%0d gnt=%b q_enq=%b expected 0100/1", c, gnt, q_enq);
            end
            cyc();
        end
        // rr_ptr is 3 again
    endtask

    task automatic test_flush();
        req = 4'b1000; req_lock = 4'b1000; #1;
        checks++;
        if (gnt !== 4'b1000) begin
            failures++; $display("[TB] FAIL flush_lockgrant gnt=%b expected 1000", gnt);
        end
        cyc();
        req = 4'b1111; flush = 1'b1; #1;
        checks++;
        if (gnt !== 4'b0000 || q_enq !== 1'b0 || locked !== 1'b1 || owner !== 2'd3) begin
            failures++;
            $display("[TB] FAIL flush_cycle gnt=%b q_enq=%b locked=%b owner=%0d expected 0000/0/1/3",
                     gnt, q_enq, locked, owner);
        end
        cyc();
        flush = 1'b0; req_lock = '0; #1;
        checks++;
        if (locked !== 1'b0 || gnt !== 4'b0001) begin
            failures++; $display("[TB] FAIL flush_after locked=%b gnt=%b expected 0/0001", locked, gnt);
        end
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        // rr_ptr is 1; lock onto requester 2, which leaves rr_ptr at 3
        req = 4'b0100; req_lock = 4'b0100; #1;
        checks++;
        if (gnt !== 4'b0100) begin
            failures++; $display("[TB] FAIL rstburst_grant gnt=%b expected 0100", gnt);
        end
        cyc();
        rst = 1'b1; req = '0;
        cyc();
        rst = 1'b0; req = 4'b1111; req_lock = '0; #1;
        checks++;
        if (locked !== 1'b0 || gnt !== 4'b0001) begin
            failures++; $display("[TB] FAIL rstburst_after locked=%b gnt=%b expected 0/0001", locked, gnt);
        end
        cyc();
        req = '0;
    endtask

`ifdef QARB_GNT_CNT_EN
    task automatic test_gnt_cnt();
        rst = 1'b1; req = '0; req_lock = '0;
        cyc();
        rst = 1'b0; req = 4'b0001;
        repeat (10) cyc();
        req = '0; flush = 1'b1;
        cyc();
        flush = 1'b0; #1;
        checks++;
        if (gnt_cnt[31:0] !== 32'd10 || gnt_cnt[127:32] !== 96'd0) begin
            failures++; $display("[TB] FAIL cnt_ten cnt0=%0d rest=%h expected 10/0", gnt_cnt[31:0], gnt_cnt[127:32]);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        checks++;
        if (gnt_cnt !== 128'd0) begin
            failures++; $display("[TB] FAIL cnt_reset cnt=%h expected 0", gnt_cnt);
        end
        cyc();
    endtask
`endif

    initial begin
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = data_of(i);
        rst = 1'b1; flush = 1'b0; req = '0; req_lock = '0; q_full = 1'b0;
        #2;
        test_reset();
        test_rotation();
        test_wrap();
        test_lock();
        test_full();
        test_single();
        test_flush();
        test_reset_mid_burst();
`ifdef QARB_GNT_CNT_EN
        test_gnt_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
